asteroid_object: RTL and testbench

//  One rock: moves on the 60 Hz frame tick and drives its pixel bit into the collision detector's pixels[14:5].

---
 rtl/asteroids_pkg.sv | 21 ++
 rtl/lfsr16.sv | 21 ++
 rtl/asteroid_object.sv | 157 +++++++++++++++
 tb/tb_asteroid_object.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Shared constants for the asteroids game: screen geometry, object FSM encoding and LFSR polynomial.
package asteroids_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_DEAD  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_ALIVE = 2'd2
  } obj_state_t;

  localparam int          LFSR_W    = 16;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with SEED on reset; shared by rock, bullet and ship spawn logic.
module lfsr16
  import asteroids_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Advance one step on every clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/asteroid_object.sv
// One rock: LFSR-driven spawn from a screen edge, wrapping motion on the frame tick, sprite pixel compare.
// Build option: ASTEROID_ROUND_MASK_EN draws the sprite as a disc instead of a square.
module asteroid_object
  import asteroids_pkg::*;
#(
  parameter int          ROCK_SIZE     = 16,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          RESPAWN_DELAY = 30,
  parameter int          VEL_MAX       = 3
) (
  input  logic       clk_60hz,
  input  logic       reset_game,
  input  logic       obj_reset,
  input  logic       enable,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       pixel,
  output logic       active,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  localparam int DW = $clog2(RESPAWN_DELAY + 1);
  localparam logic signed [2:0] VMAX = 3'(VEL_MAX);

  obj_state_t        state_r;
  logic [DW-1:0]     delay_cnt_r;
  logic signed [2:0] vx_r, vy_r;
  logic [15:0]       lfsr_s;
  logic [9:0]        rx_s, ry_s, spawn_x_s, spawn_y_s;
  logic signed [2:0] spawn_vx_s, spawn_vy_s;
  logic [9:0]        dx_s, dy_s;
  logic              in_box_s, round_ok_s;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk_60hz),
    .rst (reset_game),
    .q   (lfsr_s)
  );

  function automatic logic signed [2:0] clamp_vel(input logic signed [2:0] v);
    if (v > VMAX) begin
      clamp_vel = VMAX;
    end else if (v < -VMAX) begin
      clamp_vel = -VMAX;
    end else begin
      clamp_vel = v;
    end
  endfunction

  // Signed 11-bit step that folds back onto 0..lim-1
  function automatic logic [9:0] wrap_add(input logic [9:0] p, input logic signed [2:0] v,
                                          input logic [9:0] lim);
    logic signed [10:0] sum;
    sum = $signed({1'b0, p}) + $signed({{8{v[2]}}, v});
    if (sum < 11'sd0) begin
      sum = sum + $signed({1'b0, lim});
    end else if (sum >= $signed({1'b0, lim})) begin
      sum = sum - $signed({1'b0, lim});
    end else begin
      sum = sum;
    end
    wrap_add = sum[9:0];
  endfunction

  // Spawn position and velocity decoded from the current LFSR value
  always_comb begin
    rx_s = (lfsr_s[15:6] >= 10'(SCREEN_W)) ? lfsr_s[15:6] - 10'(SCREEN_W) : lfsr_s[15:6];
    ry_s = ({1'b0, lfsr_s[12:4]} >= 10'(SCREEN_H)) ? {1'b0, lfsr_s[12:4]} - 10'(SCREEN_H)
                                                    : {1'b0, lfsr_s[12:4]};
    case (lfsr_s[1:0])
      2'd0:    begin spawn_x_s = rx_s;                 spawn_y_s = 10'd0;                 end
      2'd1:    begin spawn_x_s = rx_s;                 spawn_y_s = 10'(SCREEN_H - 1);     end
      2'd2:    begin spawn_x_s = 10'd0;                spawn_y_s = ry_s;                  end
      default: begin spawn_x_s = 10'(SCREEN_W - 1);    spawn_y_s = ry_s;                  end
    endcase
    spawn_vx_s = clamp_vel($signed(lfsr_s[4:2]));
    if (spawn_vx_s == 3'sd0) begin
      spawn_vx_s = 3'sd1;
    end else begin
      spawn_vx_s = spawn_vx_s;
    end
    spawn_vy_s = clamp_vel($signed(lfsr_s[7:5]));
  end

  // Object FSM with position/velocity registers; active tracks ALIVE
  always_ff @(posedge clk_60hz or posedge reset_game) begin
    if (reset_game) begin
      state_r     <= ST_DEAD;
      delay_cnt_r <= DW'(RESPAWN_DELAY);
      pos_x       <= 10'd0;
      pos_y       <= 10'd0;
      vx_r        <= 3'sd0;
      vy_r        <= 3'sd0;
      active      <= 1'b0;
    end else begin
      case (state_r)
        ST_DEAD: begin
          if (enable) begin
            if (delay_cnt_r == DW'(0)) begin
              state_r <= ST_SPAWN;
            end else begin
              delay_cnt_r <= delay_cnt_r - DW'(1);
            end
          end
        end
        ST_SPAWN: begin
          pos_x   <= spawn_x_s;
          pos_y   <= spawn_y_s;
          vx_r    <= spawn_vx_s;
          vy_r    <= spawn_vy_s;
          state_r <= ST_ALIVE;
          active  <= 1'b1;
        end
        ST_ALIVE: begin
          // A hit outranks motion in the same tick
          if (obj_reset) begin
            state_r     <= ST_DEAD;
            delay_cnt_r <= DW'(RESPAWN_DELAY);
            active      <= 1'b0;
          end else if (enable) begin
            pos_x <= wrap_add(pos_x, vx_r, 10'(SCREEN_W));
            pos_y <= wrap_add(pos_y, vy_r, 10'(SCREEN_H));
          end
        end
        default: begin
          state_r <= ST_DEAD;
          active  <= 1'b0;
        end
      endcase
    end
  end

  // Beam-in-sprite test; unsigned differences clip the sprite at right/bottom edges
  always_comb begin
    dx_s     = px - pos_x;
    dy_s     = py - pos_y;
    in_box_s = active && (dx_s < 10'(ROCK_SIZE)) && (dy_s < 10'(ROCK_SIZE));
  end

`ifdef ASTEROID_ROUND_MASK_EN
  localparam int R = ROCK_SIZE / 2;
  logic signed [23:0] ox_s, oy_s;

  // Disc mask around the box centre
  always_comb begin
    ox_s       = $signed({14'd0, dx_s}) - 24'sd0 - 24'(R);
    oy_s       = $signed({14'd0, dy_s}) - 24'(R);
    round_ok_s = (ox_s * ox_s + oy_s * oy_s) <= 24'(R * R);
  end
`else
  assign round_ok_s = 1'b1;
`endif

  assign pixel = in_box_s && round_ok_s;

endmodule

// File: tb/tb_asteroid_object.sv
// Scoreboard bench for asteroid_object: a behavioural model predicts state/position every tick.
`timescale 1ns/1ps
module tb_asteroid_object;

  localparam int W = 640, H = 480, RD = 30, VMAX = 3;
  localparam int M_DEAD = 0, M_SPAWN = 1, M_ALIVE = 2;

  logic       clk_60hz = 1'b0;
  logic       reset_game = 1'b0, obj_reset = 1'b0, enable = 1'b0;
  logic [9:0] px = 10'd0, py = 10'd0;
  logic       pixel, active;
  logic [9:0] pos_x, pos_y;

  asteroid_object dut (
    .clk_60hz(clk_60hz), .reset_game(reset_game), .obj_reset(obj_reset), .enable(enable),
    .px(px), .py(py), .pixel(pixel), .active(active), .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 clk_60hz = ~clk_60hz;

  typedef struct packed { logic act; logic [9:0] x; logic [9:0] y; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int m_state, m_delay, m_x, m_y, m_vx, m_vy, m_edge;
  logic [15:0] m_lfsr;
  int first_x, first_y;

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ ((16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10));
    return r;
  endfunction

  function automatic int ref_vel(input logic [2:0] b);
    int v;
    v = int'(b);
    if (v > 3) v = v - 8;
    if (v > VMAX) v = VMAX;
    if (v < -VMAX) v = -VMAX;
    return v;
  endfunction

  function automatic int ref_wrap(input int p, input int v, input int lim);
    int s;
    s = p + v;
    if (s < 0) s = s + lim;
    if (s >= lim) s = s - lim;
    return s;
  endfunction

  task automatic model_reset();
    m_state = M_DEAD; m_delay = RD; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic ob, input logic en);
    int rx, ry;
    if (m_state == M_DEAD) begin
      if (en) begin
        if (m_delay == 0) m_state = M_SPAWN;
        else m_delay = m_delay - 1;
      end
    end else if (m_state == M_SPAWN) begin
      rx = int'(m_lfsr[15:6]); if (rx >= W) rx = rx - W;
      ry = int'(m_lfsr[12:4]); if (ry >= H) ry = ry - H;
      m_edge = int'(m_lfsr[1:0]);
      if (m_edge == 0)      begin m_x = rx;    m_y = 0;     end
      else if (m_edge == 1) begin m_x = rx;    m_y = H - 1; end
      else if (m_edge == 2) begin m_x = 0;     m_y = ry;    end
      else                  begin m_x = W - 1; m_y = ry;    end
      m_vx = ref_vel(m_lfsr[4:2]);
      if (m_vx == 0) m_vx = 1;
      m_vy = ref_vel(m_lfsr[7:5]);
      m_state = M_ALIVE;
    end else begin
      if (ob) begin
        m_state = M_DEAD; m_delay = RD;
      end else if (en) begin
        m_x = ref_wrap(m_x, m_vx, W);
        m_y = ref_wrap(m_y, m_vy, H);
      end
    end
    m_lfsr = ref_next(m_lfsr);
  endtask

  // Drive one frame tick: predict, push, clock, pop and compare
  task automatic tick(input logic ob, input logic en);
    exp_t e, got;
    obj_reset = ob; enable = en;
    model_step(ob, en);
    e.act = (m_state == M_ALIVE); e.x = m_x[9:0]; e.y = m_y[9:0];
    sb.push_back(e);
    @(posedge clk_60hz); #1;
    got = {active, pos_x, pos_y};
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL tick at %0t: got act=%0b x=%0d y=%0d, want act=%0b x=%0d y=%0d",
                 $time, got.act, got.x, got.y, e.act, e.x, e.y);
      end
    end
    obj_reset = 1'b0;
  endtask

  task automatic do_reset();
    px = 10'd0; py = 10'd0;
    reset_game = 1'b1; #2;
    checks++;
    if ({active, pixel, pos_x, pos_y} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: active=%0b pixel=%0b x=%0d y=%0d, want all 0", active, pixel, pos_x, pos_y);
    end
    reset_game = 1'b0;
    model_reset();
  endtask

  task automatic wait_alive();
    for (int n = 0; n < 100 && m_state != M_ALIVE; n++) tick(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 1; i <= RD + 2; i++) begin
      tick(1'b0, 1'b1);
      px = pos_x; py = pos_y; #1;
      checks++;
      if (active !== (i >= RD + 2) || pixel !== (i >= RD + 2)) begin
        errors++;
        $display("FAIL reset_delay edge %0d: active=%0b pixel=%0b, want %0b", i, active, pixel, i >= RD + 2);
      end
    end
    first_x = m_x; first_y = m_y;
  endtask

  task automatic test_spawn();
    logic ok;
    if (m_edge == 0)      ok = (pos_y == 10'd0);
    else if (m_edge == 1) ok = (pos_y == 10'd479);
    else if (m_edge == 2) ok = (pos_x == 10'd0);
    else                  ok = (pos_x == 10'd639);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL spawn_edge: edge=%0d x=%0d y=%0d not on that edge", m_edge, pos_x, pos_y);
    end
  endtask

  task automatic test_pixel();
    int dxs[7] = '{0, 15, 16, -1, 8, 8, 0};
    int dys[7] = '{0, 15, 0, 0, 8, 0, 16};
`ifdef ASTEROID_ROUND_MASK_EN
    logic ex[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    logic ex[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    logic [9:0] tx, ty;
    wait_alive();
    for (int k = 0; k < 7; k++) begin
      tx = 10'(m_x + dxs[k]); ty = 10'(m_y + dys[k]);
      px = tx; py = ty; #1;
      checks++;
      if (pixel !== ex[k]) begin
        errors++; $display("FAIL pixel_probe (%0d,%0d): got %0b want %0b", dxs[k], dys[k], pixel, ex[k]);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 700; i++) tick(1'b0, 1'b1);
  endtask

  task automatic test_hit();
    int en_edges = 0;
    logic en;
    wait_alive();
    tick(1'b1, 1'b1);
    px = pos_x; py = pos_y; #1;
    checks++;
    if (active !== 1'b0 || pixel !== 1'b0) begin
      errors++; $display("FAIL hit_kill: active=%0b pixel=%0b, want 0 0", active, pixel);
    end
    for (int n = 0; n < 200; n++) begin
      en = !(n >= 15 && n < 20);
      if (en) en_edges++;
      tick(n == 10, en);
      if (active === 1'b1) break;
    end
    checks++;
    if (en_edges !== RD + 2) begin
      errors++; $display("FAIL respawn_delay: enabled edges=%0d want %0d", en_edges, RD + 2);
    end
  endtask

  task automatic test_enable_low();
    int sx, sy;
    wait_alive();
    sx = m_x; sy = m_y;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    checks++;
    if (pos_x !== 10'(sx) || pos_y !== 10'(sy)) begin
      errors++; $display("FAIL freeze: x=%0d y=%0d want %0d %0d", pos_x, pos_y, sx, sy);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (active !== 1'b0) begin
      errors++; $display("FAIL kill_while_disabled: active=%0b want 0", active);
    end
    wait_alive();
  endtask

  task automatic test_reset_mid_spawn();
    wait_alive();
    tick(1'b1, 1'b1);
    for (int n = 0; n < 100 && m_state != M_SPAWN; n++) tick(1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < RD + 2; i++) tick(1'b0, 1'b1);
    checks++;
    if (pos_x !== 10'(first_x) || pos_y !== 10'(first_y) || active !== 1'b1) begin
      errors++;
      $display("FAIL reseed_spawn: x=%0d y=%0d act=%0b want %0d %0d 1", pos_x, pos_y, active, first_x, first_y);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_spawn();
    test_pixel();
    test_wrap();
    test_pixel();
    test_hit();
    test_spawn();
    test_enable_low();
    test_reset_mid_spawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
